alu_exec_stage: RTL and testbench
=================================

# alu_exec_stage

Execute stage of the Yinger MIPS core: consumes the 4-bit ALU control code from the ALU control decoder plus two operands, computes the result, and holds it in an EX/MEM output register with a two-entry skid buffer. It decouples the decode/issue side from the memory/writeback side with valid/ready handshakes, so a downstream stall never drops or duplicates an operation. The zero flag it produces drives branch resolution (BEQ/BNE use the SUB code).

## Interface
Parameters:
- WIDTH, 32, operand/result width
- REGW, 5, destination register index width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-low
- flush  input  1  synchronous squash of all held entries, active-high
- in_valid  input  1  upstream has an operation
- in_ready  output  1  stage can accept this cycle
- alu_ct  input  4  operation code
- op_a  input  WIDTH  operand A (rs)
- op_b  input  WIDTH  operand B (rt or extended immediate)
- in_dst  input  REGW  destination register index
- in_wen  input  1  operation writes the register file
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts this cycle
- out_result  output  WIDTH  ALU result
- out_zero  output  1  out_result == 0
- out_dst  output  REGW  passthrough of in_dst
- out_wen  output  1  passthrough of in_wen

## Operation
- Codes: 0000 AND; 0001 OR; 0010 ADD (modulo 2^WIDTH, no overflow trap); 0011 XOR; 0100 NOR; 0110 SUB (op_a − op_b modulo 2^WIDTH); 1000 SLTU (1 if op_a < op_b unsigned, else 0, zero-extended); any other code → result 0.
- Result and zero flag computed combinationally from inputs at accept time and captured with in_dst/in_wen; held values never recompute.
- Storage: main entry (drives outputs) and skid entry. States: EMPTY (main invalid), ONE (main valid, skid empty), FULL (both valid).
- Accept = in_valid && in_ready. Drain = out_valid && out_ready.
- EMPTY: accept → ONE (data into main).
- ONE: accept && drain → ONE (main replaced); accept && !drain → FULL (data into skid); drain only → EMPTY; neither → hold.
- FULL: drain → ONE (skid moves to main); no accept possible.
- in_ready = registered, 1 unless state FULL. out_valid = main valid.
- Output fields stable while out_valid && !out_ready.
- flush: next edge → EMPTY, in_ready 1; an accept in the flush cycle is discarded; a drain in the flush cycle still counts downstream.
- rst has priority over flush.

## Timing
- Reset (rst=0 at edge): state EMPTY, in_ready 1, out_valid 0, out_result 0, out_zero 1, out_dst 0, out_wen 0, skid cleared.
- Latency: op accepted at edge N appears with out_valid=1 in cycle after N (1 cycle).
- Throughput: 1 op/cycle while out_ready stays high.
- in_ready falls the cycle after entering FULL, rises the cycle after the draining edge; no combinational path out_ready → in_ready.
- Ordering strictly FIFO; no op lost or duplicated across any stall pattern.
- rst asserted mid-stream: all held ops discarded at that edge regardless of handshakes.

## Test plan
- Reset: hold rst=0 two cycles with in_valid=1 → out_valid 0, in_ready 1, out_zero 1, out_result 0 after release.
- Arithmetic: out_ready=1; issue ADD 0xFFFFFFFF+1, SUB 5−5, SLTU 1<0xFFFFFFFF, NOR 0,0, code 0101 → results 0 (zero=1), 0 (zero=1), 1, 0xFFFFFFFF, 0 on consecutive cycles, one cycle after each accept.
- Backpressure: stream ops A,B,C with out_ready=0 → A held on outputs, B in skid, in_ready 0 next cycle, C not accepted; raise out_ready → A, B, C emerge in order, none repeated.
- Simultaneous accept/drain in ONE: every cycle in_valid=1, out_ready=1 → state stays ONE, 1 op/cycle, out_dst tracks in_dst delayed one cycle.
- Flush: in FULL assert flush with in_valid=1 → next cycle out_valid 0, in_ready 1, flushed-cycle input absent downstream.
- Passthrough: in_dst=31, in_wen=1 with XOR 0xA5A5A5A5,0x5A5A5A5A → out_result 0xFFFFFFFF, out_dst 31, out_wen 1, out_zero 0.

Source files
------------

// File: rtl/alu_exec_stage.sv
// Execute stage: ALU plus EX/MEM register with a two-entry skid buffer.
// Result and zero flag are captured at accept time and never recomputed.
//
// state | meaning
// EMPTY | main entry invalid, outputs idle
// ONE   | main entry valid, skid empty
// FULL  | main and skid both valid, upstream stalled
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [REGW-1:0]  in_dst,
  input  logic             in_wen,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic [REGW-1:0]  out_dst,
  output logic             out_wen
);

  localparam logic [3:0] CT_AND  = 4'b0000;
  localparam logic [3:0] CT_OR   = 4'b0001;
  localparam logic [3:0] CT_ADD  = 4'b0010;
  localparam logic [3:0] CT_XOR  = 4'b0011;
  localparam logic [3:0] CT_NOR  = 4'b0100;
  localparam logic [3:0] CT_SUB  = 4'b0110;
  localparam logic [3:0] CT_SLTU = 4'b1000;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_m_result;
  logic             r_m_zero;
  logic [REGW-1:0]  r_m_dst;
  logic             r_m_wen;
  logic [WIDTH-1:0] r_s_result;
  logic             r_s_zero;
  logic [REGW-1:0]  r_s_dst;
  logic             r_s_wen;

  logic [WIDTH-1:0] w_result;
  logic             w_zero;
  logic             w_accept;
  logic             w_drain;

  always_comb begin
    w_result = '0;
    case (alu_ct)
      CT_AND:  w_result = op_a & op_b;
      CT_OR:   w_result = op_a | op_b;
      CT_ADD:  w_result = op_a + op_b;
      CT_XOR:  w_result = op_a ^ op_b;
      CT_NOR:  w_result = ~(op_a | op_b);
      CT_SUB:  w_result = op_a - op_b;
      CT_SLTU: w_result = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      default: w_result = '0;
    endcase
  end

  assign w_zero   = (w_result == '0);
  assign w_accept = in_valid && r_in_ready;
  assign w_drain  = out_valid && out_ready;

  assign in_ready   = r_in_ready;
  assign out_valid  = (r_state != S_EMPTY);
  assign out_result = r_m_result;
  assign out_zero   = r_m_zero;
  assign out_dst    = r_m_dst;
  assign out_wen    = r_m_wen;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
      r_m_result <= '0;
      r_m_zero   <= 1'b1;
      r_m_dst    <= '0;
      r_m_wen    <= 1'b0;
      r_s_result <= '0;
      r_s_zero   <= 1'b1;
      r_s_dst    <= '0;
      r_s_wen    <= 1'b0;
    end else if (flush) begin
      // Entries are dropped by state alone; held data is simply ignored.
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_m_result <= w_result;
            r_m_zero   <= w_zero;
            r_m_dst    <= in_dst;
            r_m_wen    <= in_wen;
            r_state    <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && w_drain) begin
            r_m_result <= w_result;
            r_m_zero   <= w_zero;
            r_m_dst    <= in_dst;
            r_m_wen    <= in_wen;
          end else if (w_accept) begin
            r_s_result <= w_result;
            r_s_zero   <= w_zero;
            r_s_dst    <= in_dst;
            r_s_wen    <= in_wen;
            r_state    <= S_FULL;
            r_in_ready <= 1'b0;
          end else if (w_drain) begin
            r_state    <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_drain) begin
            r_m_result <= r_s_result;
            r_m_zero   <= r_s_zero;
            r_m_dst    <= r_s_dst;
            r_m_wen    <= r_s_wen;
            r_state    <= S_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_EMPTY;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: reset, ALU codes, backpressure,
// flush, mid-stream reset and field passthrough.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ct;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  in_dst;
  logic        in_wen;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic [4:0]  out_dst;
  logic        out_wen;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(.WIDTH(32), .REGW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_ct(alu_ct), .op_a(op_a), .op_b(op_b),
    .in_dst(in_dst), .in_wen(in_wen),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .out_dst(out_dst), .out_wen(out_wen)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_errors++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
  endtask

  task automatic drive(input logic [3:0] ct, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] dst, input logic wen);
    in_valid = 1'b1;
    alu_ct   = ct;
    op_a     = a;
    op_b     = b;
    in_dst   = dst;
    in_wen   = wen;
  endtask

  // One accept per cycle with out_ready high; result must appear the next cycle.
  task automatic issue(input string tag, input logic [3:0] ct, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] dst, input logic [31:0] exp);
    drive(ct, a, b, dst, 1'b0);
    tick();
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_result"}, out_result, exp);
    chk({tag, "_zero"}, {31'd0, out_zero}, {31'd0, (exp == 32'd0)});
    chk({tag, "_dst"}, {27'd0, out_dst}, {27'd0, dst});
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(4'b0010, 32'd1, 32'd2, 5'd7, 1'b1);

    // Reset held two cycles with in_valid asserted
    tick(); tick();
    rst = 1'b1; in_valid = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_zero", {31'd0, out_zero}, 32'd1);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_dst", {27'd0, out_dst}, 32'd0);
    chk("rst_out_wen", {31'd0, out_wen}, 32'd0);
    tick();
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);

    // Back-to-back ops, accept and drain in the same cycle
    out_ready = 1'b1;
    issue("add_wrap",  4'b0010, 32'hFFFF_FFFF, 32'd1,        5'd1, 32'h0000_0000);
    issue("sub_eq",    4'b0110, 32'd5,         32'd5,        5'd2, 32'h0000_0000);
    issue("sltu_t",    4'b1000, 32'd1,         32'hFFFF_FFFF, 5'd3, 32'h0000_0001);
    issue("nor_0",     4'b0100, 32'd0,         32'd0,        5'd4, 32'hFFFF_FFFF);
    issue("code_0101", 4'b0101, 32'd123,       32'd456,      5'd5, 32'h0000_0000);
    issue("sltu_f",    4'b1000, 32'hFFFF_FFFF, 32'd1,        5'd6, 32'h0000_0000);
    issue("and",       4'b0000, 32'h0000_F0F0, 32'h0000_0FF0, 5'd7, 32'h0000_00F0);
    issue("or",        4'b0001, 32'h0000_F0F0, 32'h0000_0FF0, 5'd8, 32'h0000_FFF0);
    issue("sub_neg",   4'b0110, 32'd3,         32'd5,        5'd9, 32'hFFFF_FFFE);
    issue("code_1111", 4'b1111, 32'hDEAD_BEEF, 32'd1,        5'd10, 32'h0000_0000);
    in_valid = 1'b0;
    tick();
    chk("drain_empty", {31'd0, out_valid}, 32'd0);

    // Backpressure: A to main, B to skid, C refused
    out_ready = 1'b0;
    drive(4'b0010, 32'd10, 32'd1, 5'd10, 1'b1);
    tick();
    chk("bp_a_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_a_ready", {31'd0, in_ready}, 32'd1);
    drive(4'b0010, 32'd20, 32'd2, 5'd11, 1'b0);
    tick();
    chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_a_hold", out_result, 32'd11);
    drive(4'b0010, 32'd30, 32'd3, 5'd12, 1'b1);
    tick();
    chk("bp_c_refused_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_a_stable_res", out_result, 32'd11);
    chk("bp_a_stable_dst", {27'd0, out_dst}, 32'd10);
    chk("bp_a_stable_wen", {31'd0, out_wen}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_b_res", out_result, 32'd22);
    chk("bp_b_dst", {27'd0, out_dst}, 32'd11);
    chk("bp_b_wen", {31'd0, out_wen}, 32'd0);
    chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_c_res", out_result, 32'd33);
    chk("bp_c_dst", {27'd0, out_dst}, 32'd12);
    in_valid = 1'b0;
    tick();
    chk("bp_no_dup", {31'd0, out_valid}, 32'd0);

    // Flush while FULL with a new op on the input
    out_ready = 1'b0;
    drive(4'b0010, 32'd40, 32'd0, 5'd20, 1'b1);
    tick();
    drive(4'b0010, 32'd50, 32'd0, 5'd21, 1'b1);
    tick();
    chk("fl_full_ready", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    drive(4'b0010, 32'd77, 32'd0, 5'd22, 1'b1);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("fl_input_absent", {31'd0, out_valid}, 32'd0);

    // Flush in ONE with a simultaneous accept: the accept is discarded
    drive(4'b0010, 32'd60, 32'd0, 5'd23, 1'b0);
    tick();
    chk("fl1_valid", {31'd0, out_valid}, 32'd1);
    flush = 1'b1;
    drive(4'b0010, 32'd61, 32'd0, 5'd24, 1'b0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl1_out_valid", {31'd0, out_valid}, 32'd0);

    // Reset mid-stream discards held ops
    out_ready = 1'b0;
    drive(4'b0011, 32'd1, 32'd2, 5'd3, 1'b1);
    tick();
    drive(4'b0011, 32'd4, 32'd8, 5'd4, 1'b1);
    tick();
    rst = 1'b0; flush = 1'b1;
    tick();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_ready", {31'd0, in_ready}, 32'd1);
    chk("mrst_result", out_result, 32'd0);
    chk("mrst_zero", {31'd0, out_zero}, 32'd1);

    // Field passthrough
    out_ready = 1'b1;
    drive(4'b0011, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 5'd31, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("pt_valid", {31'd0, out_valid}, 32'd1);
    chk("pt_result", out_result, 32'hFFFF_FFFF);
    chk("pt_dst", {27'd0, out_dst}, 32'd31);
    chk("pt_wen", {31'd0, out_wen}, 32'd1);
    chk("pt_zero", {31'd0, out_zero}, 32'd0);
    tick();
    chk("pt_drained", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
